// File: rtl/mux_scan_sequencer_if.sv
// Bundle of the mux select/sample pair, the start request and the downstream valid/ready word port.
// The sequencer uses the master modport. The mux and the consumer sit on the slave side.
interface mux_scan_sequencer_if;
  logic       start;
  logic [3:0] s;
  logic       y;
  logic [7:0] word;
  logic       valid;
  logic       ready;
  logic       busy;

  modport master (
    input  start, y, ready,
    output s, word, valid, busy
  );

  modport slave (
    output start, y, ready,
    input  s, word, valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks the 8:1 mux select through channels 0..7 and packs the sampled bits into one word.
// Optional macro MUX_SCAN_AUTO_RESTART_EN: after each handshake, start the next scan immediately.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_scan_sequencer_if.master  bus
);

  localparam int unsigned CH_W   = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 8;

  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;
  localparam bit               HAS_SETTLE = (SETTLE > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // State entered whenever a new channel is selected.
  localparam state_t CH_ENTRY = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     w_ch_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [WORD_W-1:0]   r_acc;
  logic [WORD_W-1:0]   w_acc_nxt;
  logic [WORD_W-1:0]   r_word;
  logic [WORD_W-1:0]   w_word_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_word  <= w_word_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_word_nxt  = r_word;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_ch_nxt    = '0;
          w_acc_nxt   = '0;
          w_cnt_nxt   = CNT_RELOAD;
          w_busy_nxt  = 1'b1;
          w_state_nxt = CH_ENTRY;
        end
      end

      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        w_acc_nxt[r_ch] = bus.y;
        if (r_ch == LAST_CH) begin
          // Publish the word using the live sample for the top bit.
          w_word_nxt  = {bus.y, r_acc[WORD_W-2:0]};
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_DONE;
        end else begin
          w_ch_nxt    = r_ch + CH_W'(1);
          w_cnt_nxt   = CNT_RELOAD;
          w_state_nxt = CH_ENTRY;
        end
      end

      ST_DONE: begin
        if (r_valid && bus.ready) begin
          w_valid_nxt = 1'b0;
          w_ch_nxt    = '0;
`ifdef MUX_SCAN_AUTO_RESTART_EN
          w_acc_nxt   = '0;
          w_cnt_nxt   = CNT_RELOAD;
          w_busy_nxt  = 1'b1;
          w_state_nxt = CH_ENTRY;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.s     = {1'b0, r_ch};
  assign bus.word  = r_word;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized bench for mux_scan_sequencer: a SETTLE=1 and a SETTLE=0 instance driven by a settling-mux model.
// Expected select walk, busy/valid timing and words are computed arithmetically from the scan rules.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start_v [2];
  logic       ready_v [2];
  logic       y_v     [2];
  logic [7:0] pat     [2];
  int         age     [2];
  logic [3:0] last_s  [2];

  logic [3:0] o_s     [2];
  logic [7:0] o_word  [2];
  logic       o_valid [2];
  logic       o_busy  [2];

  int errors = 0;
  int checks = 0;

  mux_scan_sequencer_if if0 ();
  mux_scan_sequencer_if if1 ();

  mux_scan_sequencer #(.SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux_scan_sequencer #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.start = start_v[0];
  assign if0.ready = ready_v[0];
  assign if0.y     = y_v[0];
  assign if1.start = start_v[1];
  assign if1.ready = ready_v[1];
  assign if1.y     = y_v[1];

  assign o_s[0]     = if0.s;
  assign o_word[0]  = if0.word;
  assign o_valid[0] = if0.valid;
  assign o_busy[0]  = if0.busy;
  assign o_s[1]     = if1.s;
  assign o_word[1]  = if1.word;
  assign o_valid[1] = if1.valid;
  assign o_busy[1]  = if1.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux model: output is the inverted bit until the select has been stable for SETTLE cycles.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (o_s[k] !== last_s[k]) age[k] = 0;
      else if (age[k] < 1000) age[k] = age[k] + 1;
      last_s[k] = o_s[k];
    end
  end

  assign y_v[0] = pat[0][o_s[0][2:0]];
  assign y_v[1] = (age[1] >= 1) ? pat[1][o_s[1][2:0]] : ~pat[1][o_s[1][2:0]];

  function automatic int settle_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  task automatic pulse_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // One full scan on instance k, checked cycle by cycle against the arithmetic timing model.
  task automatic run_scan(input int k, input logic [7:0] p, input int hold, input int glitch_n, input string tag);
    int         st;
    int         lat;
    int         ch_exp;
    logic [3:0] exp_s;
    st  = settle_of(k);
    lat = 8 * (st + 1);
    pat[k]     = p;
    ready_v[k] = (hold == 0);
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      ch_exp = n / (st + 1);
      if (ch_exp > 7) ch_exp = 7;
      exp_s = 4'(ch_exp);
      checks++;
      if (o_s[k] !== exp_s) begin
        errors++;
        $display("FAIL %s s n=%0d: got %0h want %0h", tag, n, o_s[k], exp_s);
      end
      checks++;
      if (o_busy[k] !== (n < lat)) begin
        errors++;
        $display("FAIL %s busy n=%0d: got %0b want %0b", tag, n, o_busy[k], (n < lat));
      end
      checks++;
      if (o_valid[k] !== (n == lat)) begin
        errors++;
        $display("FAIL %s valid n=%0d: got %0b want %0b", tag, n, o_valid[k], (n == lat));
      end
      if (n == lat) begin
        checks++;
        if (o_word[k] !== p) begin
          errors++;
          $display("FAIL %s word: got %02h want %02h", tag, o_word[k], p);
        end
      end
      if (n < lat) begin
        start_v[k] = (n == glitch_n);
        @(posedge clk); #1;
        start_v[k] = 1'b0;
      end
    end
    for (int h = 0; h < hold; h++) begin
      start_v[k] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (o_valid[k] !== 1'b1 || o_word[k] !== p || o_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s hold h=%0d: got valid=%0b word=%02h busy=%0b want 1/%02h/0", tag, h,
                 o_valid[k], o_word[k], o_busy[k], p);
      end
    end
    start_v[k] = 1'b0;
    ready_v[k] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_valid[k] !== 1'b0 || o_s[k] !== 4'd0) begin
      errors++;
      $display("FAIL %s handshake: got valid=%0b s=%0h want 0/0", tag, o_valid[k], o_s[k]);
    end
`ifdef MUX_SCAN_AUTO_RESTART_EN
    checks++;
    if (o_busy[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s restart busy: got %0b want 1", tag, o_busy[k]);
    end
    pulse_reset();
`else
    checks++;
    if (o_busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s idle busy: got %0b want 0", tag, o_busy[k]);
    end
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_s[k] !== 4'd0 || o_word[k] !== 8'h00 || o_valid[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: got s=%0h word=%02h valid=%0b busy=%0b want all 0", k,
                 o_s[k], o_word[k], o_valid[k], o_busy[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_busy[k] !== 1'b0 || o_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_start dut%0d: got busy=%0b valid=%0b want 0/0", k, o_busy[k], o_valid[k]);
      end
    end
  endtask

  task automatic test_basic;
    run_scan(1, 8'hA5, 0, -1, "basic");
  endtask

  task automatic test_zero_settle;
    run_scan(0, 8'h3C, 0, -1, "zero_settle");
    for (int i = 0; i < 3; i++) run_scan(0, 8'($urandom), 0, -1, "zero_settle_rand");
  endtask

  task automatic test_backpressure;
    run_scan(1, 8'($urandom), 20, -1, "backpressure");
    run_scan(1, 8'($urandom), 0, -1, "after_bp");
    run_scan(0, 8'($urandom), $urandom_range(1, 6), -1, "backpressure0");
  endtask

  task automatic test_mid_scan_reset;
    int cyc;
    run_scan(1, 8'h5A, 0, -1, "pre_reset");
    pat[1]     = 8'($urandom);
    ready_v[1] = 1'b1;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    cyc = 0;
    while (o_s[1] !== 4'd4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 100) begin
      errors++;
      $display("FAIL mid_reset wait: got s=%0h want 4 within 100 cycles", o_s[1]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_s[1] !== 4'd0 || o_word[1] !== 8'h00 || o_valid[1] !== 1'b0 || o_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset outputs: got s=%0h word=%02h valid=%0b busy=%0b want all 0",
               o_s[1], o_word[1], o_valid[1], o_busy[1]);
    end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_busy[1] !== 1'b0 || o_s[1] !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset idle: got busy=%0b s=%0h want 0/0", o_busy[1], o_s[1]);
    end
    run_scan(1, 8'hFF, 0, -1, "post_reset_ff");
    run_scan(1, 8'($urandom), 0, -1, "post_reset_rand");
  endtask

  task automatic test_start_during_busy;
    run_scan(1, 8'($urandom), 0, 6, "start_busy");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (o_valid[1] !== 1'b0 || o_busy[1] !== 1'b0) begin
        errors++;
        $display("FAIL start_busy extra: got valid=%0b busy=%0b want 0/0", o_valid[1], o_busy[1]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int k;
    for (int i = 0; i < 8; i++) begin
      k = int'($urandom_range(0, 1));
      run_scan(k, 8'($urandom), int'($urandom_range(0, 3)), -1, "b2b");
    end
  endtask

  task automatic test_auto_restart;
`ifdef MUX_SCAN_AUTO_RESTART_EN
    logic [7:0] p;
    logic [3:0] exp_s;
    int         ch_exp;
    ready_v[1] = 1'b1;
    pat[1]     = 8'h0F;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    for (int sc = 0; sc < 4; sc++) begin
      p      = (sc % 2 == 0) ? 8'h0F : 8'hF0;
      pat[1] = p;
      for (int n = 0; n <= 16; n++) begin
        ch_exp = (n / 2 > 7) ? 7 : n / 2;
        exp_s  = 4'(ch_exp);
        checks++;
        if (o_s[1] !== exp_s || o_busy[1] !== (n < 16) || o_valid[1] !== (n == 16)) begin
          errors++;
          $display("FAIL auto sc=%0d n=%0d: got s=%0h busy=%0b valid=%0b want %0h/%0b/%0b", sc, n,
                   o_s[1], o_busy[1], o_valid[1], exp_s, (n < 16), (n == 16));
        end
        if (n == 16) begin
          checks++;
          if (o_word[1] !== p) begin
            errors++;
            $display("FAIL auto word sc=%0d: got %02h want %02h", sc, o_word[1], p);
          end
        end
        @(posedge clk); #1;
      end
    end
    pulse_reset();
`endif
  endtask

  initial begin
    rst        = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    ready_v[0] = 1'b0;
    ready_v[1] = 1'b0;
    pat[0]     = 8'h00;
    pat[1]     = 8'h00;
    test_reset();
    test_basic();
    test_zero_settle();
    test_backpressure();
    test_mid_scan_reset();
    test_start_during_busy();
    test_back_to_back();
    test_auto_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Scan sequencer that drives the select input of the 8:1 channel multiplexer (`mux81`), steps through channels 0–7 and samples the single-bit mux output for each channel. It assembles the eight samples into one 8-bit word and hands that word downstream over a valid/ready handshake. It is the control stage directly upstream and downstream of `mux81`: it feeds the mux's `s` and consumes its `y`.

## Interface
Parameters:
- `SETTLE`, default 1: wait cycles after each select change before sampling, legal range 0–15.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begins a scan; sampled only in IDLE.
- `s`, output, 4: mux select; `s[3]` is constant 0 and `s[2:0]` is the current channel.
- `y`, input, 1: mux output being sampled.
- `word`, output, 8: last completed scan; `word[n]` is the value of `y` sampled while `s==n`.
- `valid`, output, 1: `word` holds an unconsumed scan.
- `ready`, input, 1: downstream accepts `word`.
- `busy`, output, 1: high in SETTLE and SAMPLE.

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE. Internally the block keeps a channel counter `ch[2:0]` (drives `s[2:0]`), a settle counter `cnt[3:0]` and a shadow register `acc[7:0]`.
- **IDLE**
  - If `start` is high: `ch` ← 0 and `acc` ← 0.
  - If `SETTLE>0`, go to SETTLE with `cnt` ← `SETTLE-1`. Otherwise go to SAMPLE.
- **SETTLE**: if `cnt==0`, go to SAMPLE; otherwise `cnt` ← `cnt-1`.
- **SAMPLE**: `acc[ch]` ← `y`.
  - If `ch==7`: `word` ← `acc` with bit 7 replaced by `y`, `valid` ← 1, go to DONE.
  - Otherwise: `ch` ← `ch+1`, then go to SETTLE (reloading `cnt`) or, when `SETTLE=0`, stay in SAMPLE.
- **DONE**: hold `word` and `valid`. When `valid && ready`: `valid` ← 0, `ch` ← 0, go to IDLE.
- `word` changes only on entry to DONE; partial scans are never visible on `word`.
- `start` is ignored outside IDLE. A start pulse arriving during SETTLE, SAMPLE or DONE is dropped, not queued.
- `ready` may be high before `valid`. The transfer occurs on the first edge where both are high.
- Reset at any point (including mid-scan):
  - Immediately sets state = IDLE, `ch` = 0, `s` = 0, `acc` = 0, `word` = 0, `valid` = 0, `busy` = 0, `cnt` = 0.
  - The partial scan is discarded.
- `ch` never wraps within a scan; it returns to 0 only via the DONE→IDLE transition or reset.

## Timing
- `s` changes on the edge that enters SETTLE/SAMPLE for the new channel. `y` is sampled `SETTLE+1` edges later, i.e. `SETTLE` full cycles of mux settling.
- Latency from the edge that samples `start` to `valid` high is exactly `8*(SETTLE+1)` cycles. SETTLE=1 gives 16 cycles; SETTLE=0 gives 8 cycles.
- `valid` falls on the edge where `valid && ready`. Without auto-restart, the earliest next `start` is sampled one cycle later, in IDLE.
- `busy` is registered:
  - rises on the edge leaving IDLE;
  - falls on the edge entering DONE.
- Reset output values: `s` = 4'b0000, `word` = 8'h00, `valid` = 0, `busy` = 0.

## Configuration
- Macro `MUX_SCAN_AUTO_RESTART_EN`.
- **Defined**: on the DONE handshake edge the block does not go to IDLE.
  - It goes directly to SETTLE (or SAMPLE if `SETTLE=0`) with `ch` = 0, `acc` = 0 and `busy` = 1, giving back-to-back scans with no IDLE cycle.
  - `start` is used only for the first scan after reset.
- **Undefined**: DONE always returns to IDLE and every scan requires a `start` pulse.

## Test plan
- **Basic scan**: reset; SETTLE=1; `y` driven as bit `s` of 8'hA5; pulse `start`; `ready` held 1 → `valid` high 16 cycles after the start edge with `word` = 8'hA5; `s` walks 0..7, each value held for 2 cycles.
- **Zero settle**: SETTLE=0; `y` = bit `s` of 8'h3C → `word` = 8'h3C after 8 cycles, `s` increments every cycle.
- **Backpressure**: `ready` = 0 for 20 cycles after `valid` → `word` and `valid` stable and `start` pulses ignored; then `ready` = 1 → `valid` drops next edge; a new `start` begins a fresh scan.
- **Mid-scan reset**: assert `rst` while `s` = 4 → `s`, `word`, `valid` and `busy` go to 0 immediately; a following scan of 8'hFF returns 8'hFF with no stale bits.
- **Start during busy**: a second `start` at `s` = 3 → no restart, and exactly one `valid` per scan.
- **Auto-restart** (macro defined): `ready` held 1, alternate patterns 8'h0F and 8'hF0 per scan → consecutive words are 8'h0F, 8'hF0 with the handshake edge immediately followed by `s` = 0 and `busy` = 1.
